// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions.
//   ptr_w()        : FIFO pointer width for a given depth (index bits plus one wrap bit)
//   axis_beat_t    : one stored stream beat, {tlast, tdata}, at the default data width
package axis_pkg;

  // Default tdata width for the stream data path.
  localparam int unsigned DATA_W_DEFAULT = 8;

  typedef struct packed {
    logic                      tlast;
    logic [DATA_W_DEFAULT-1:0] tdata;
  } axis_beat_t;

  // The extra MSB distinguishes full from empty when the index bits match.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array.
//   clk   : write clock
//   we    : write enable, writes wdata to mem[waddr] on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : asynchronous read data, mem[raddr]
module fifo_ram #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_rx_fifo.sv
// AXI-Stream receive FIFO with first-word fall-through output.
//   clk, rst          : clock, asynchronous active-high reset
//   op_en             : low stalls both ports, contents kept
//   flush             : synchronous clear of all entries (wins over push/pop)
//   s_tdata/tlast/tvalid, s_tready : stream input
//   m_tdata/tlast/tvalid, m_tready : stream output, head of FIFO
//   level, empty, full, almost_full : occupancy status from registered pointers
module axis_rx_fifo
  import axis_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_en,
  input  logic                   flush,
  input  logic [DATA_W-1:0]      s_tdata,
  input  logic                   s_tlast,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [DATA_W-1:0]      m_tdata,
  output logic                   m_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;
  localparam logic [PW-1:0] AfThresh = PW'(AF_THRESH);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            push, pop;
  logic [DATA_W:0] ram_rdata;

  // Status decodes from registered pointers only.
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                       (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level       = wr_ptr_q - rd_ptr_q;
  assign almost_full = (level >= AfThresh);

  // Gating by rst keeps both handshakes low while in reset. s_tready
  // deliberately ignores m_tready so no combinational path exists between them.
  assign s_tready = op_en & ~full & ~flush & ~rst;
  assign m_tvalid = op_en & ~empty & ~flush & ~rst;

  assign push = s_tvalid & s_tready;
  assign pop  = m_tvalid & m_tready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fifo_ram #(
    .WIDTH(DATA_W + 1),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr_q[AW-1:0]),
    .wdata({s_tlast, s_tdata}),
    .raddr(rd_ptr_q[AW-1:0]),
    .rdata(ram_rdata)
  );

  assign m_tdata = ram_rdata[DATA_W-1:0];
  assign m_tlast = ram_rdata[DATA_W];

endmodule
